ps2_key_event_ctrl: RTL and testbench
=====================================

PS2_KEY_EVENT_CTRL -- requirements
Module: ps2_key_event_ctrl

Interface
REQ-001 FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.
REQ-002 PREFIX_TIMEOUT, 2500000, clk cycles a prefix state waits for its next byte.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_valid  input  1  one-cycle strobe; a PS/2 byte was received.
REQ-006 rx_data  input  8  received byte, valid with rx_valid.
REQ-007 rx_error  input  1  qualifies rx_valid; parity/framing error.
REQ-008 evt_valid  output  1  FIFO head holds an event.
REQ-009 evt_ready  input  1  consumer accepts head when evt_valid is high.
REQ-010 evt_key  output  4  key index of head event.
REQ-011 evt_release  output  1  head event is a release (1) or press (0).
REQ-012 key_state  output  16  current pressed bitmap, bit n = key index n.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  entries held.
REQ-014 overflow  output  1  sticky; an event was dropped.
REQ-015 clr_overflow  input  1  clears overflow.

Function
REQ-016 Key map, index 0..15: 16,1E,26,25,2E,36,3D,3E,46,15,1D,24,2D,2C,35,3C (hex); any other code is unmapped.
REQ-017 Decoder FSM states IDLE, BRK, EXT, EXT_BRK; only rx_valid cycles advance it.
REQ-018 IDLE: F0 -> BRK; E0 -> EXT; mapped code -> press event, stay IDLE; anything else ignored.
REQ-019 BRK: mapped code -> release event; any byte -> IDLE.
REQ-020 EXT: F0 -> EXT_BRK; any other byte -> IDLE, no event.
REQ-021 EXT_BRK: any byte -> IDLE, no event (extended keys unsupported).
REQ-022 rx_valid with rx_error high: FSM -> IDLE, no event, key_state unchanged.
REQ-023 Non-IDLE state with no rx_valid for PREFIX_TIMEOUT cycles -> IDLE, no event; counter clears on every rx_valid and on entry to IDLE.
REQ-024 Press sets key_state bit, release clears it, on the same edge that captures the final byte.
REQ-025 Event appears on evt_valid the cycle after the final byte's rx_valid (latency 1).
REQ-026 FIFO is first-word-fall-through; pop when evt_valid && evt_ready.
REQ-027 Push when full and no simultaneous pop: event dropped, overflow set, key_state still updated.
REQ-028 Push and pop same cycle when full: both occur, no overflow, level unchanged.
REQ-029 Pop when empty: ignored, level stays 0.
REQ-030 clr_overflow and a dropping push in same cycle: overflow remains set.

Reset
REQ-031 rst: FSM IDLE, timeout counter 0, FIFO empty, fifo_level 0, evt_valid 0, evt_key 0, evt_release 0, key_state 0, overflow 0.
REQ-032 Reset mid-sequence (e.g. after F0) discards the partial sequence; next mapped byte is a press.

Configuration
REQ-033 PS2_TYPEMATIC_FILTER_EN defined: press for a key already set in key_state, or release for a key already clear, produces no event.
REQ-034 PS2_TYPEMATIC_FILTER_EN undefined: every decoded press/release is enqueued, including typematic repeats.

Structure
REQ-035 Package ps2_pkg holds scan-code constants, prefix codes E0/F0, FSM state enum, 4-bit key index typedef.
REQ-036 FIFO is sub-module ps2_event_fifo (5-bit entries: release, key).

Verification
REQ-037 Bytes 1E then F0 1E -> events {press,1}, {release,1}; key_state 0002 then 0000.
REQ-038 E0 F0 16 -> no event, key_state 0000, FSM IDLE.
REQ-039 F0, idle PREFIX_TIMEOUT cycles, then 16 -> press key 0, not release.
REQ-040 evt_ready 0, FIFO_DEPTH+1 presses of distinct keys -> fifo_level 4, overflow 1, key_state has 5 bits set.
REQ-041 16 16 16 -> 1 event with PS2_TYPEMATIC_FILTER_EN, 3 without.
REQ-042 rst asserted after F0, released, byte 26 -> press key 2; 26 with rx_error -> no event.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder definitions: prefix codes, the 16-key scan-code map,
// decoder state encoding and the key-index type.
package ps2_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;

  typedef logic [3:0] key_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } dec_state_t;

  typedef struct packed {
    logic     hit;
    key_idx_t idx;
  } key_lookup_t;

  localparam logic [7:0] KEY_CODES [16] = '{
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
    8'h46, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C
  };

  function automatic key_lookup_t key_lookup(input logic [7:0] code);
    key_lookup_t r;
    r.hit = 1'b0;
    r.idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (KEY_CODES[i] == code) begin
        r.hit = 1'b1;
        r.idx = key_idx_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; head is visible whenever not empty.
// A push into a full FIFO is dropped unless a pop happens on the same edge.
module ps2_event_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic                       rd_vld,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     count;
  logic              full;
  logic              do_pop;
  logic              do_push;

  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_vld  = (count != '0);
  assign rd_data = rd_vld ? mem[rd_ptr] : '0;
  assign level   = count;

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 set-2 scan-code decoder producing press/release events into a FIFO.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses redundant press/release events.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 2500000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_error,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [3:0]                    evt_key,
  output logic                          evt_release,
  output logic [15:0]                   key_state,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

  dec_state_t   state;
  dec_state_t   state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  key_lookup_t   lk;
  logic          byte_ok;
  logic          dec_press;
  logic          dec_rel;
  logic          evt_vld_p0;
  logic [4:0]    evt_data_p0;
  logic [15:0]   key_state_nxt;
  logic [4:0]    head_data;
  logic          drop;

  assign tmo_hit = (state != ST_IDLE) && !rx_valid && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (rx_valid || (state == ST_IDLE) || tmo_hit) tmo_cnt <= '0;
      else                                           tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (rx_valid) begin
      if (rx_error) begin
        state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_data == SC_F0)      state_nxt = ST_BRK;
            else if (rx_data == SC_E0) state_nxt = ST_EXT;
          end
          ST_EXT:  state_nxt = (rx_data == SC_F0) ? ST_EXT_BRK : ST_IDLE;
          default: state_nxt = ST_IDLE;
        endcase
      end
    end else if (tmo_hit) begin
      state_nxt = ST_IDLE;
    end
  end

  // Stage p0: decoded event from the byte on rx_data, enqueued on this edge.
  always_comb begin
    lk        = key_lookup(rx_data);
    byte_ok   = rx_valid && !rx_error && lk.hit;
    dec_press = byte_ok && (state == ST_IDLE);
    dec_rel   = byte_ok && (state == ST_BRK);
`ifdef PS2_TYPEMATIC_FILTER_EN
    evt_vld_p0 = (dec_press && !key_state[lk.idx]) || (dec_rel && key_state[lk.idx]);
`else
    evt_vld_p0 = dec_press || dec_rel;
`endif
    evt_data_p0   = {dec_rel, lk.idx};
    key_state_nxt = key_state;
    if (dec_press) key_state_nxt[lk.idx] = 1'b1;
    if (dec_rel)   key_state_nxt[lk.idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_state <= '0;
      overflow  <= 1'b0;
    end else begin
      key_state <= key_state_nxt;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  ps2_event_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (5)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (evt_vld_p0),
    .push_data (evt_data_p0),
    .pop       (evt_ready),
    .rd_vld    (evt_valid),
    .rd_data   (head_data),
    .level     (fifo_level),
    .drop      (drop)
  );

  assign evt_release = head_data[4];
  assign evt_key     = head_data[3:0];

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Bench for ps2_key_event_ctrl: directed vector table, corner sequences and a
// random run checked against a byte-sequence reference model.
module tb_ps2_key_event_ctrl;

  localparam int D = 4;
  localparam int T = 16;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_error = 1'b0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [3:0]  evt_key;
  logic        evt_release;
  logic [15:0] key_state;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        clr_overflow = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  ps2_key_event_ctrl #(.FIFO_DEPTH(D), .PREFIX_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_error     (rx_error),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_key      (evt_key),
    .evt_release  (evt_release),
    .key_state    (key_state),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  logic [7:0] codes [16] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                             8'h46, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C};

  // Reference model: pending prefix bytes, idle counter, pressed set, event queue.
  logic [7:0]  seq [$];
  int          idle_n;
  logic [15:0] m_ks;
  logic [4:0]  m_q [$];
  logic        m_ovf;

  function automatic int map_idx(input logic [7:0] c);
    for (int i = 0; i < 16; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    seq.delete();
    m_q.delete();
    idle_n = 0;
    m_ks = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [7:0] d, input logic e,
                            input logic rdy, input logic clr);
    bit pop, ev, full, drop;
    logic [4:0] ent;
    int k;
    pop = (m_q.size() > 0) && rdy;
    ev = 1'b0;
    ent = '0;
    if (rv) begin
      idle_n = 0;
      if (e) seq.delete();
      else begin
        seq.push_back(d);
        k = map_idx(d);
        if (seq.size() == 1) begin
          if (d != 8'hF0 && d != 8'hE0) begin
            if (k >= 0) begin
              ev = !(FILT && m_ks[k]);
              ent = {1'b0, 4'(k)};
              m_ks[k] = 1'b1;
            end
            seq.delete();
          end
        end else if (seq.size() == 2 && seq[0] == 8'hF0) begin
          if (k >= 0) begin
            ev = !(FILT && !m_ks[k]);
            ent = {1'b1, 4'(k)};
            m_ks[k] = 1'b0;
          end
          seq.delete();
        end else if (!(seq.size() == 2 && d == 8'hF0)) begin
          seq.delete();
        end
      end
    end else if (seq.size() > 0) begin
      idle_n++;
      if (idle_n >= T) begin
        seq.delete();
        idle_n = 0;
      end
    end
    full = (m_q.size() == D);
    drop = ev && full && !pop;
    if (pop) void'(m_q.pop_front());
    if (ev && !drop) m_q.push_back(ent);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [4:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 5'h00;
    chk({tag, ".evt_valid"}, 32'(evt_valid), 32'(m_q.size() > 0));
    chk({tag, ".evt_key"}, 32'(evt_key), 32'(head[3:0]));
    chk({tag, ".evt_release"}, 32'(evt_release), 32'(head[4]));
    chk({tag, ".key_state"}, 32'(key_state), 32'(m_ks));
    chk({tag, ".fifo_level"}, 32'(fifo_level), 32'(m_q.size()));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cyc(input logic rv, input logic [7:0] d, input logic e,
                     input logic rdy, input logic clr, input string tag);
    rx_valid = rv;
    rx_data = d;
    rx_error = e;
    evt_ready = rdy;
    clr_overflow = clr;
    model_step(rv, d, e, rdy, clr);
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_error = 1'b0;
    evt_ready = 1'b0;
    clr_overflow = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #3;
    chk("rst.evt_valid", 32'(evt_valid), 32'd0);
    chk("rst.evt_key", 32'(evt_key), 32'd0);
    chk("rst.evt_release", 32'(evt_release), 32'd0);
    chk("rst.key_state", 32'(key_state), 32'd0);
    chk("rst.fifo_level", 32'(fifo_level), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rv;
    logic [7:0]  d;
    logic        e;
    logic        rdy;
    logic        clr;
    logic        xv;
    logic [3:0]  xk;
    logic        xr;
    logic [15:0] xks;
    logic [2:0]  xl;
    logic        xo;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1'b1, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 16'h0002, 3'd1, 1'b0};
    tbl[1]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 16'h0002, 3'd1, 1'b0};
    tbl[2]  = '{1'b1, 8'h1E, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 16'h0000, 3'd2, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 16'h0000, 3'd1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd0, 1'b0};
    tbl[5]  = '{1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd0, 1'b0};
    tbl[6]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd0, 1'b0};
    tbl[7]  = '{1'b1, 8'h16, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd0, 1'b0};
    tbl[8]  = '{1'b1, 8'h26, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 3'd0, 1'b0};
    tbl[9]  = '{1'b1, 8'h26, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 16'h0004, 3'd1, 1'b0};
    tbl[10] = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 16'h0004, 3'd1, 1'b0};
    tbl[11] = '{1'b1, 8'h26, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 16'h0004, 3'd1, 1'b0};
    tbl[12] = '{1'b1, 8'h25, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 16'h000C, 3'd2, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 16'h000C, 3'd1, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h000C, 3'd0, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h000C, 3'd0, 1'b0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rv, tbl[i].d, tbl[i].e, tbl[i].rdy, tbl[i].clr, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.valid", i), 32'(evt_valid), 32'(tbl[i].xv));
      chk($sformatf("vec%0d.key", i), 32'(evt_key), 32'(tbl[i].xk));
      chk($sformatf("vec%0d.rel", i), 32'(evt_release), 32'(tbl[i].xr));
      chk($sformatf("vec%0d.ks", i), 32'(key_state), 32'(tbl[i].xks));
      chk($sformatf("vec%0d.level", i), 32'(fifo_level), 32'(tbl[i].xl));
      chk($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(tbl[i].xo));
    end

    // Prefix timeout: T idle cycles after F0 drop the prefix, T-1 do not.
    do_reset();
    cyc(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, "tmo");
    idle(T, "tmo");
    cyc(1'b1, 8'h16, 1'b0, 1'b0, 1'b0, "tmo");
    chk("tmo.press_rel", 32'(evt_release), 32'd0);
    chk("tmo.press_key", 32'(evt_key), 32'd0);
    chk("tmo.press_ks", 32'(key_state), 32'h0001);
    cyc(1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, "tmo");
    idle(T - 1, "tmo");
    cyc(1'b1, 8'h16, 1'b0, 1'b0, 1'b0, "tmo");
    chk("tmo.edge_rel", 32'(evt_release), 32'd1);
    chk("tmo.edge_ks", 32'(key_state), 32'h0000);

    // Overflow, clear-vs-drop priority, and push+pop while full.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, codes[i], 1'b0, 1'b0, 1'b0, "ovf");
    chk("ovf.level", 32'(fifo_level), 32'd4);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.ks", 32'(key_state), 32'h001F);
    cyc(1'b1, codes[5], 1'b0, 1'b0, 1'b1, "ovf");
    chk("ovf.clr_vs_drop", 32'(overflow), 32'd1);
    chk("ovf.ks_drop", 32'(key_state), 32'h003F);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "ovf");
    chk("ovf.cleared", 32'(overflow), 32'd0);
    cyc(1'b1, codes[6], 1'b0, 1'b1, 1'b0, "ovf");
    chk("ovf.pushpop_level", 32'(fifo_level), 32'd4);
    chk("ovf.pushpop_flag", 32'(overflow), 32'd0);
    chk("ovf.pushpop_head", 32'(evt_key), 32'd1);

    // Typematic repeats.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h16, 1'b0, 1'b0, 1'b0, "typ");
    chk("typ.level", 32'(fifo_level), FILT ? 32'd1 : 32'd3);

    // Reset in the middle of a break sequence.
    do_reset();
    cyc(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, "mid");
    do_reset();
    cyc(1'b1, 8'h26, 1'b0, 1'b0, 1'b0, "mid");
    chk("mid.key", 32'(evt_key), 32'd2);
    chk("mid.rel", 32'(evt_release), 32'd0);
    cyc(1'b1, 8'h26, 1'b1, 1'b0, 1'b0, "mid");
    chk("mid.err_level", 32'(fifo_level), 32'd1);

    // Random traffic: busy phase then sparse phase to exercise timeouts.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic rv, e, rdy, clr;
      logic [7:0] d;
      int sel;
      rv = (i < 1500) ? ($urandom_range(1) == 1) : ($urandom_range(9) == 0);
      sel = $urandom_range(9);
      if (sel < 5)       d = codes[$urandom_range(15)];
      else if (sel < 7)  d = 8'hF0;
      else if (sel < 8)  d = 8'hE0;
      else               d = 8'($urandom);
      e = ($urandom_range(15) == 0);
      rdy = ($urandom_range(2) == 0);
      clr = ($urandom_range(19) == 0);
      cyc(rv, d, e, rdy, clr, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
